// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out 8 data + odd parity + stop,
// then check the device ACK. Optional single resend on failure when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 975000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  // Clock is held for INHIBIT_CYCLES in total: INHIBIT lasts one cycle less, REQ supplies the last.
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
  localparam logic [WW-1:0] TO_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLAST    = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, DONE, ERR
  } state_t;

  // line index 0 = ps2_clk, 1 = ps2_data
  logic [1:0]         raw;
  logic [1:0][1:0]    sync;
  logic [1:0][FW-1:0] fcnt;
  logic [1:0]         filt;
  logic               filt_clk_d;
  logic               fall;

  assign raw  = {ps2_data_i, ps2_clk_i};
  assign fall = filt_clk_d & ~filt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '1;
      filt       <= '1;
      fcnt       <= '0;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][0], raw[i]};
        if (sync[i][1] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLAST) begin
          filt[i] <= sync[i][1];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [WW-1:0] wd, wd_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    sr, sr_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic          busy_n, done_n, err_n, clk_oe_n, data_oe_n;
  logic          wd_run, timeout, fail;
`ifdef PS2_TX_RETRY_EN
  logic          retried, retried_n;
`endif

  assign wd_run  = (state == BITS) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = wd_run && !fall && (wd == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      wd          <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      tx_byte     <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      wd          <= wd_n;
      bit_cnt     <= bit_cnt_n;
      sr          <= sr_n;
      tx_byte     <= tx_byte_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
`ifdef PS2_TX_RETRY_EN
      retried     <= retried_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    wd_n      = wd;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    tx_byte_n = tx_byte;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retried_n = retried;
`endif

    if (wd_run) wd_n = fall ? '0 : wd + 1'b1;

    case (state)
      IDLE: begin
`ifdef PS2_TX_RETRY_EN
        retried_n = 1'b0;
`endif
        if (tx_start) begin
          tx_byte_n = tx_data;
          clk_oe_n  = 1'b1;
          busy_n    = 1'b1;
          inh_cnt_n = '0;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          sr_n      = {1'b1, ~^tx_byte, tx_byte};
          state_n   = REQ;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        clk_oe_n  = 1'b0;
        wd_n      = '0;
        bit_cnt_n = '0;
        state_n   = BITS;
      end
      BITS: begin
        // sr[0] is the next bit; the stop bit is 1 so its fall releases the data line
        if (fall) begin
          data_oe_n = ~sr[0];
          sr_n      = {1'b0, sr[9:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (!filt[1]) state_n = WAIT_IDLE;
          else          fail    = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (filt[0] && filt[1]) begin
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ERR: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (timeout) fail = 1'b1;

    if (fail) begin
      done_n    = 1'b0;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        // data released; clock pulled again to start a fresh inhibit for the resend
        retried_n = 1'b1;
        clk_oe_n  = 1'b1;
        inh_cnt_n = '0;
        state_n   = INHIBIT;
      end else begin
        err_n   = 1'b1;
        state_n = ERR;
      end
`else
      err_n   = 1'b1;
      state_n = ERR;
`endif
    end
  end

endmodule
